uart_prog_loader: RTL

- UART boot loader upstream of the CPU core.
- Receives a program over a serial line (8N1) and assembles bytes into 32-bit words.
- Writes each word into instruction memory through a single-cycle write port.
- Holds the CPU in reset while loading, then releases it.

---
 rtl/uart_prog_loader.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/uart_prog_loader.sv
// UART (8N1) boot loader: assembles little-endian 32-bit words from the serial line,
// writes them into instruction memory and holds the CPU in reset while loading.
module uart_prog_loader #(
  parameter int unsigned CLKS_PER_BIT = 2604,
  parameter int unsigned ADDR_W       = 14
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_load,
  input  logic              rx,
  output logic              prog_we,
  output logic [ADDR_W-1:0] prog_addr,
  output logic [31:0]       prog_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              frame_err
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} top_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  top_state_t        top_q, top_d;
  rx_state_t         rx_q, rx_d;
  logic              rx_meta, rxs;
  logic [BAUD_W-1:0] baud_q;
  logic [2:0]        bit_q;
  logic [7:0]        shift_q;
  logic [1:0]        byte_cnt_q;
  logic [23:0]       word_q;

  logic        baud_half, baud_last, stop_sample, byte_ok, byte_bad;
  logic        word_ready, is_term, last_write, start_req;
  logic [31:0] word_full;

  always_comb begin
    baud_half   = (baud_q == BAUD_HALF);
    baud_last   = (baud_q == BAUD_LAST);
    stop_sample = (rx_q == RX_STOP) && baud_last;
    byte_ok     = stop_sample && rxs;
    byte_bad    = stop_sample && !rxs;
    word_full   = {shift_q, word_q};
    word_ready  = byte_ok && (byte_cnt_q == 2'd3);
    is_term     = word_ready && (word_full == 32'hFFFF_FFFF);
    last_write  = prog_we && (prog_addr == {ADDR_W{1'b1}});
    start_req   = ((top_q == IDLE) || (top_q == DONE)) && start_load;
  end

  // Top-level load sequencing
  always_comb begin
    top_d = top_q;
    case (top_q)
      IDLE, DONE: if (start_load) top_d = LOAD;
      LOAD:       if (is_term || last_write) top_d = DONE;
      default:    top_d = IDLE;
    endcase
  end

  // Receiver sequencing; parked in RX_IDLE outside of LOAD
  always_comb begin
    rx_d = rx_q;
    if (top_q != LOAD) begin
      rx_d = RX_IDLE;
    end else begin
      case (rx_q)
        RX_IDLE:  if (!rxs) rx_d = RX_START;
        RX_START: if (baud_half) rx_d = rxs ? RX_IDLE : RX_DATA;
        RX_DATA:  if (baud_last && (bit_q == 3'd7)) rx_d = RX_STOP;
        RX_STOP:  if (baud_last) rx_d = RX_IDLE;
        default:  rx_d = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      top_q <= IDLE;
      rx_q  <= RX_IDLE;
    end else begin
      top_q <= top_d;
      rx_q  <= rx_d;
    end
  end

  // rx synchronizer, baud/bit counters and byte shifter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
      if ((rx_q == RX_IDLE) || (rx_d != rx_q) || baud_last) baud_q <= '0;
      else                                                  baud_q <= baud_q + BAUD_W'(1);
      if (rx_q != RX_DATA) begin
        bit_q <= '0;
      end else if (baud_last) begin
        bit_q   <= bit_q + 3'd1;
        shift_q <= {rxs, shift_q[7:1]};
      end
    end
  end

  // Word assembly, write strobe and status outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prog_we    <= 1'b0;
      prog_addr  <= '0;
      prog_wdata <= '0;
      cpu_hold   <= 1'b0;
      done       <= 1'b0;
      frame_err  <= 1'b0;
      byte_cnt_q <= '0;
      word_q     <= '0;
    end else begin
      prog_we  <= 1'b0;
      cpu_hold <= (top_d == LOAD);
      done     <= (top_d == DONE);
      if (start_req) begin
        prog_addr  <= '0;
        byte_cnt_q <= '0;
        word_q     <= '0;
        frame_err  <= 1'b0;
      end else if (top_q == LOAD) begin
        if (byte_bad) frame_err <= 1'b1;
        if (prog_we) prog_addr <= prog_addr + ADDR_W'(1);
        if (byte_ok) begin
          byte_cnt_q <= byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0:    word_q[7:0]   <= shift_q;
            2'd1:    word_q[15:8]  <= shift_q;
            2'd2:    word_q[23:16] <= shift_q;
            default: word_q        <= word_q;
          endcase
          if (word_ready && !is_term) begin
            prog_we    <= 1'b1;
            prog_wdata <= word_full;
          end
        end
      end
    end
  end

endmodule
